// File: rtl/decode_issue_unit.sv
// Registered decode-and-issue stage: holds one instruction, tracks in-flight destinations
// and the mul/div busy window. Optional macro DECODE_WB_BYPASS_EN releases dependents in the writeback cycle.
module decode_issue_unit #(
  parameter  int NUM_REGS   = 32,
  parameter  int PC_W       = 12,
  parameter  int MD_LATENCY = 32,
  parameter  int LINK_REG   = 31,
  parameter  int STATUS_REG = 30,
  localparam int REG_W      = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_insn,
  input  logic [PC_W-1:0]     in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_insn,
  output logic [PC_W-1:0]     out_pc,
  output logic [1:0]          out_type,
  output logic [14:0]         out_ctrl,
  output logic [REG_W-1:0]    out_dst,
  output logic [REG_W-1:0]    out_src_a,
  output logic [REG_W-1:0]    out_src_b,
  output logic                out_writes,
  output logic                out_need_a,
  output logic                out_need_b,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_reg,
  output logic                md_busy,
  output logic [NUM_REGS-1:0] pending
);

  localparam logic [REG_W-1:0] LINK_IDX   = REG_W'(LINK_REG);
  localparam logic [REG_W-1:0] STATUS_IDX = REG_W'(STATUS_REG);
  localparam logic [7:0]       MD_LOAD    = 8'(MD_LATENCY);

  logic                hold_valid_q, hold_valid_d;
  logic [31:0]         insn_q, insn_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [7:0]          md_cnt_q, md_cnt_d;

  logic [4:0]       opcode, alu_op;
  logic [REG_W-1:0] rd, rs, rt;
  logic is_alu, is_add, is_sub, is_mul, is_div, is_addi, is_sw, is_lw;
  logic is_j, is_bne, is_jal, is_jr, is_blt, is_bex, is_setx;
  logic [NUM_REGS-1:0] eff_pending;
  logic hazard, fire;

  assign opcode = insn_q[31:27];
  assign alu_op = insn_q[6:2];
  assign rd     = insn_q[22 +: REG_W];
  assign rs     = insn_q[17 +: REG_W];
  assign rt     = insn_q[12 +: REG_W];

  assign is_alu  = (opcode == 5'd0);
  assign is_add  = is_alu && (alu_op == 5'd0);
  assign is_sub  = is_alu && (alu_op == 5'd1);
  assign is_mul  = is_alu && (alu_op == 5'd6);
  assign is_div  = is_alu && (alu_op == 5'd7);
  assign is_j    = (opcode == 5'd1);
  assign is_bne  = (opcode == 5'd2);
  assign is_jal  = (opcode == 5'd3);
  assign is_jr   = (opcode == 5'd4);
  assign is_addi = (opcode == 5'd5);
  assign is_blt  = (opcode == 5'd6);
  assign is_sw   = (opcode == 5'd7);
  assign is_lw   = (opcode == 5'd8);
  assign is_setx = (opcode == 5'd21);
  assign is_bex  = (opcode == 5'd22);

  assign out_ctrl = {is_setx, is_bex, is_blt, is_jr, is_jal, is_bne, is_j,
                     is_lw, is_sw, is_div, is_mul, is_addi, is_sub, is_add, is_alu};

  always_comb begin
    out_type = 2'd0;
    if (is_jr)                                 out_type = 2'd3;
    else if (is_j || is_jal || is_bex || is_setx) out_type = 2'd2;
    else if (is_sw || is_lw || is_bne || is_blt)  out_type = 2'd1;
  end

  always_comb begin
    out_dst = rd;
    if (is_jal)       out_dst = LINK_IDX;
    else if (is_setx) out_dst = STATUS_IDX;
  end

  assign out_src_a  = is_bex ? STATUS_IDX : rs;
  assign out_src_b  = (is_bne || is_blt || is_jr || is_sw) ? rd : rt;
  assign out_writes = (is_alu || is_addi || is_lw || is_jal || is_setx) && (out_dst != '0);
  assign out_need_a = is_alu || is_addi || is_sw || is_lw || is_bne || is_blt || is_bex;
  assign out_need_b = (is_alu && (alu_op != 5'd8) && (alu_op != 5'd9)) || is_bne || is_jr || is_blt;

`ifdef DECODE_WB_BYPASS_EN
  logic [NUM_REGS-1:0] wb_mask;
  assign wb_mask     = wb_valid ? (NUM_REGS'(1) << wb_reg) : '0;
  assign eff_pending = pending_q & ~wb_mask;
`else
  assign eff_pending = pending_q;
`endif

  assign hazard = (out_need_a && (out_src_a != '0) && eff_pending[out_src_a]) ||
                  (out_need_b && (out_src_b != '0) && eff_pending[out_src_b]) ||
                  (out_writes && eff_pending[out_dst]) ||
                  ((is_mul || is_div) && (md_cnt_q != 8'd0));

  assign out_valid = hold_valid_q && !hazard && !flush;
  assign fire      = out_valid && out_ready;
  assign in_ready  = !flush && (!hold_valid_q || fire);
  assign out_insn  = insn_q;
  assign out_pc    = pc_q;
  assign md_busy   = (md_cnt_q != 8'd0);
  assign pending   = pending_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    insn_d       = insn_q;
    pc_d         = pc_q;
    if (flush) begin
      hold_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      hold_valid_d = 1'b1;
      insn_d       = in_insn;
      pc_d         = in_pc;
    end else if (fire) begin
      hold_valid_d = 1'b0;
    end

    // Set after clear so an issuing writer wins over a same-register retire.
    pending_d = pending_q;
    if (wb_valid)             pending_d[wb_reg]  = 1'b0;
    if (fire && out_writes)   pending_d[out_dst] = 1'b1;
    pending_d[0] = 1'b0;

    md_cnt_d = md_cnt_q;
    if (fire && (is_mul || is_div)) md_cnt_d = MD_LOAD;
    else if (md_cnt_q != 8'd0)      md_cnt_d = md_cnt_q - 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid_q <= 1'b0;
      insn_q       <= '0;
      pc_q         <= '0;
      pending_q    <= '0;
      md_cnt_q     <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      insn_q       <= insn_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      md_cnt_q     <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_issue_unit.sv
// Bench for decode_issue_unit: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a behavioural model of the issue rules.
module tb_decode_issue_unit;
  localparam int NUM_REGS = 32;
  localparam int PC_W     = 12;
  localparam int MD_LAT   = 4;
  localparam int REG_W    = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                reset_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]         in_insn, out_insn;
  logic [PC_W-1:0]     in_pc, out_pc;
  logic [1:0]          out_type;
  logic [14:0]         out_ctrl;
  logic [REG_W-1:0]    out_dst, out_src_a, out_src_b, wb_reg;
  logic                out_writes, out_need_a, out_need_b, wb_valid, md_busy;
  logic [NUM_REGS-1:0] pending;

  decode_issue_unit #(.NUM_REGS(NUM_REGS), .PC_W(PC_W), .MD_LATENCY(MD_LAT),
                      .LINK_REG(31), .STATUS_REG(30)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc), .out_type(out_type),
    .out_ctrl(out_ctrl), .out_dst(out_dst), .out_src_a(out_src_a), .out_src_b(out_src_b),
    .out_writes(out_writes), .out_need_a(out_need_a), .out_need_b(out_need_b),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .md_busy(md_busy), .pending(pending));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  typ;
    logic [14:0] ctrl;
    logic [4:0]  dst, sa, sb;
    logic        wr, na, nb, md;
  } dec_t;

  // Class bit positions in out_ctrl (alu is bit 0, setx is bit 14).
  localparam int C_ALU = 0, C_ADD = 1, C_SUB = 2, C_ADDI = 3, C_MUL = 4, C_DIV = 5, C_SW = 6,
                 C_LW = 7, C_J = 8, C_BNE = 9, C_JAL = 10, C_JR = 11, C_BLT = 12, C_BEX = 13,
                 C_SETX = 14;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    logic [4:0] op, aop, rd, rs, rt;
    op = w[31:27]; aop = w[6:2]; rd = w[26:22]; rs = w[21:17]; rt = w[16:12];
    d.typ = 2'd0; d.ctrl = '0; d.dst = rd; d.sa = rs; d.sb = rt;
    d.wr = 1'b0; d.na = 1'b0; d.nb = 1'b0; d.md = 1'b0;
    case (op)
      5'd0: begin
        d.ctrl[C_ALU] = 1'b1; d.wr = 1'b1; d.na = 1'b1;
        d.nb = !(aop == 5'd8 || aop == 5'd9);
        if (aop == 5'd0) d.ctrl[C_ADD] = 1'b1;
        if (aop == 5'd1) d.ctrl[C_SUB] = 1'b1;
        if (aop == 5'd6) begin d.ctrl[C_MUL] = 1'b1; d.md = 1'b1; end
        if (aop == 5'd7) begin d.ctrl[C_DIV] = 1'b1; d.md = 1'b1; end
      end
      5'd1:  begin d.ctrl[C_J] = 1'b1; d.typ = 2'd2; end
      5'd2:  begin d.ctrl[C_BNE] = 1'b1; d.typ = 2'd1; d.sb = rd; d.na = 1'b1; d.nb = 1'b1; end
      5'd3:  begin d.ctrl[C_JAL] = 1'b1; d.typ = 2'd2; d.dst = 5'd31; d.wr = 1'b1; end
      5'd4:  begin d.ctrl[C_JR] = 1'b1; d.typ = 2'd3; d.sb = rd; d.nb = 1'b1; end
      5'd5:  begin d.ctrl[C_ADDI] = 1'b1; d.na = 1'b1; d.wr = 1'b1; end
      5'd6:  begin d.ctrl[C_BLT] = 1'b1; d.typ = 2'd1; d.sb = rd; d.na = 1'b1; d.nb = 1'b1; end
      5'd7:  begin d.ctrl[C_SW] = 1'b1; d.typ = 2'd1; d.sb = rd; d.na = 1'b1; end
      5'd8:  begin d.ctrl[C_LW] = 1'b1; d.typ = 2'd1; d.na = 1'b1; d.wr = 1'b1; end
      5'd21: begin d.ctrl[C_SETX] = 1'b1; d.typ = 2'd2; d.dst = 5'd30; d.wr = 1'b1; end
      5'd22: begin d.ctrl[C_BEX] = 1'b1; d.typ = 2'd2; d.sa = 5'd30; d.na = 1'b1; end
      default: ;
    endcase
    d.wr = d.wr && (d.dst != 5'd0);
    return d;
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] aop);
    return {op, rd, rs, rt, 5'd0, aop, 2'b00};
  endfunction

  // Behavioural model state
  logic                m_hv;
  logic [31:0]         m_insn;
  logic [PC_W-1:0]     m_pc;
  logic [NUM_REGS-1:0] m_pend;
  int                  m_md;
  dec_t                m_dec;
  logic                e_ov, e_ir, e_fire;

  task automatic model_reset();
    m_hv = 1'b0; m_insn = '0; m_pc = '0; m_pend = '0; m_md = 0;
  endtask

  task automatic eval_model();
    logic [NUM_REGS-1:0] p;
    logic haz;
    p = m_pend;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_valid) p[wb_reg] = 1'b0;
`endif
    m_dec = decode(m_insn);
    haz = (m_dec.na && m_dec.sa != 5'd0 && p[m_dec.sa]) ||
          (m_dec.nb && m_dec.sb != 5'd0 && p[m_dec.sb]) ||
          (m_dec.wr && p[m_dec.dst]) ||
          (m_dec.md && m_md != 0);
    e_ov   = m_hv && !haz && !flush;
    e_fire = e_ov && out_ready;
    e_ir   = !flush && (!m_hv || e_fire);
  endtask

  task automatic compare();
    check("in_ready", in_ready, e_ir);
    check("out_valid", out_valid, e_ov);
    check("md_busy", md_busy, m_md != 0);
    check("pending", pending, m_pend);
    if (m_hv) begin
      check("out_insn", out_insn, m_insn);
      check("out_pc", out_pc, m_pc);
      check("out_type", out_type, m_dec.typ);
      check("out_ctrl", out_ctrl, m_dec.ctrl);
      check("out_dst", out_dst, m_dec.dst);
      check("out_src_a", out_src_a, m_dec.sa);
      check("out_src_b", out_src_b, m_dec.sb);
      check("out_writes", out_writes, m_dec.wr);
      check("out_need_a", out_need_a, m_dec.na);
      check("out_need_b", out_need_b, m_dec.nb);
    end
  endtask

  task automatic model_update();
    if (wb_valid) m_pend[wb_reg] = 1'b0;
    if (e_fire && m_dec.wr) m_pend[m_dec.dst] = 1'b1;
    m_pend[0] = 1'b0;
    if (e_fire && m_dec.md) m_md = MD_LAT;
    else if (m_md > 0)      m_md = m_md - 1;
    if (flush) m_hv = 1'b0;
    else if (in_valid && e_ir) begin m_hv = 1'b1; m_insn = in_insn; m_pc = in_pc; end
    else if (e_fire) m_hv = 1'b0;
  endtask

  task automatic cycle();
    #2;
    eval_model();
    compare();
    @(posedge clock);
    model_update();
    #1;
  endtask

  int ops[12]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22, 9};
  int aops[6]  = '{0, 1, 6, 7, 8, 3};

  function automatic logic [4:0] rand_reg();
    if ($urandom_range(3) == 0) return 5'(28 + $urandom_range(3));
    return 5'($urandom_range(7));
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [4:0] op, aop;
    logic [31:0] w;
    op  = 5'(ops[$urandom_range(11)]);
    aop = 5'(aops[$urandom_range(5)]);
    w = enc(op, rand_reg(), rand_reg(), rand_reg(), aop);
    w[11:7] = 5'($urandom);
    w[1:0]  = 2'($urandom);
    return w;
  endfunction

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_insn = '0; in_pc = '0; flush = 1'b0;
    out_ready = 1'b0; wb_valid = 1'b0; wb_reg = '0;
    model_reset();
    #8;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_md_busy", md_busy, 1'b0);
    check("rst_pending", pending, 32'h0);
    #4 reset_n = 1'b1;
    @(posedge clock); #1;

    // add r3,r1,r2
    in_valid = 1'b1; in_insn = enc(5'd0, 5'd3, 5'd1, 5'd2, 5'd0); in_pc = 12'h100; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; #1;
    check("add_valid", out_valid, 1'b1);
    check("add_ctrl", out_ctrl, 15'h0003);
    check("add_dst", out_dst, 5'd3);
    check("add_type", out_type, 2'd0);
    cycle();
    check("add_pending", pending, 32'h0000_0008);

    // addi r5 then dependent sub r6,r5,r1
    in_valid = 1'b1; in_insn = enc(5'd5, 5'd5, 5'd1, 5'd0, 5'd0); in_pc = 12'h104;
    cycle();
    in_insn = enc(5'd0, 5'd6, 5'd5, 5'd1, 5'd1); in_pc = 12'h108;
    cycle();
    in_valid = 1'b0; #1;
    check("sub_stall", out_valid, 1'b0);
    check("sub_pending", pending, 32'h0000_0028);
    cycle();
    check("sub_stall2", out_valid, 1'b0);
    wb_valid = 1'b1; wb_reg = 5'd5; #1;
`ifdef DECODE_WB_BYPASS_EN
    check("sub_wb_cycle", out_valid, 1'b1);
`else
    check("sub_wb_cycle", out_valid, 1'b0);
`endif
    cycle();
    wb_valid = 1'b0; #1;
`ifdef DECODE_WB_BYPASS_EN
    check("sub_after_wb", out_valid, 1'b0);
`else
    check("sub_after_wb", out_valid, 1'b1);
`endif
    cycle();
    check("sub_issued_pending", pending, 32'h0000_0048);

    // mul r7 then div r8: structural stall for MD_LAT cycles
    in_valid = 1'b1; in_insn = enc(5'd0, 5'd7, 5'd1, 5'd2, 5'd6);
    cycle();
    in_insn = enc(5'd0, 5'd8, 5'd1, 5'd2, 5'd7);
    cycle();
    in_valid = 1'b0; #1;
    check("div_md_busy", md_busy, 1'b1);
    check("div_stall", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("div_stall_n", out_valid, 1'b0);
    end
    cycle();
    check("div_release", out_valid, 1'b1);
    check("div_md_idle", md_busy, 1'b0);
    cycle();
    check("div_md_reload", md_busy, 1'b1);

    // jal, bex, setx then bex
    in_valid = 1'b1; in_insn = enc(5'd3, 5'd0, 5'd0, 5'd0, 5'd0);
    cycle();
    in_valid = 1'b0; #1;
    check("jal_dst", out_dst, 5'd31);
    check("jal_type", out_type, 2'd2);
    cycle();
    check("jal_pending31", pending[31], 1'b1);
    in_valid = 1'b1; in_insn = enc(5'd22, 5'd0, 5'd0, 5'd0, 5'd0);
    cycle();
    in_valid = 1'b0; #1;
    check("bex_src_a", out_src_a, 5'd30);
    check("bex_no_stall", out_valid, 1'b1);
    cycle();
    in_valid = 1'b1; in_insn = enc(5'd21, 5'd0, 5'd0, 5'd0, 5'd0);
    cycle();
    in_insn = enc(5'd22, 5'd0, 5'd0, 5'd0, 5'd0);
    cycle();
    in_valid = 1'b0; #1;
    check("bex_after_setx", out_valid, 1'b0);
    check("setx_pending30", pending[30], 1'b1);
    wb_valid = 1'b1; wb_reg = 5'd30;
    cycle();
    wb_valid = 1'b0;
    cycle();
    cycle();

    // add writing r0, then flush of a stalled instruction
    check("pre_r0_pending", pending, 32'h8000_01C8);
    in_valid = 1'b1; in_insn = enc(5'd0, 5'd0, 5'd1, 5'd2, 5'd0);
    cycle();
    in_valid = 1'b0; #1;
    check("r0_writes", out_writes, 1'b0);
    check("r0_valid", out_valid, 1'b1);
    cycle();
    check("r0_pending", pending, 32'h8000_01C8);
    in_valid = 1'b1; in_insn = enc(5'd0, 5'd9, 5'd31, 5'd1, 5'd1);
    cycle();
    in_valid = 1'b0; #1;
    check("flush_pre_stall", out_valid, 1'b0);
    flush = 1'b1; #1;
    check("flush_in_ready", in_ready, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    cycle();
    flush = 1'b0; #1;
    check("flush_after_valid", out_valid, 1'b0);
    check("flush_after_ready", in_ready, 1'b1);
    check("flush_pending", pending, 32'h8000_01C8);

    // reset asserted while an instruction waits on out_ready
    out_ready = 1'b0;
    in_valid = 1'b1; in_insn = enc(5'd0, 5'd11, 5'd1, 5'd2, 5'd0);
    cycle();
    in_valid = 1'b0; #1;
    check("stall_valid", out_valid, 1'b1);
    cycle();
    #2 reset_n = 1'b0; #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_ready", in_ready, 1'b1);
    check("async_rst_pending", pending, 32'h0);
    check("async_rst_md", md_busy, 1'b0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(9) < 7);
      in_insn   = rand_insn();
      in_pc     = PC_W'($urandom);
      out_ready = ($urandom_range(9) < 7);
      flush     = ($urandom_range(24) == 0);
      wb_valid  = 1'b0;
      wb_reg    = 5'($urandom);
      if (m_pend != '0 && $urandom_range(2) == 0) begin
        for (int t = 0; t < 64; t++) begin
          int k;
          k = $urandom_range(NUM_REGS - 1);
          if (m_pend[k]) begin
            wb_valid = 1'b1;
            wb_reg   = 5'(k);
            break;
          end
        end
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
